// File: rtl/video_timing_pkg.sv
// Shared raster types, per-mode timing sets and decode helpers for video_timing_gen.
// Mode select: VIDEO_1080P, VIDEO_720P or VIDEO_480P (848x480); with none defined, 640x480@60.
package video_timing_pkg;

    typedef logic [11:0] coord_t;

    localparam int COORD_LIMIT = 4096;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hsync_pol;
        bit vsync_pol;
    } timing_t;

    // 25 MHz pixel clock
    localparam timing_t MODE_VGA_640X480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    // 34 MHz pixel clock
    localparam timing_t MODE_WVGA_848X480 = '{
        h_active: 848, h_fp: 16, h_sync: 112, h_bp: 112,
        v_active: 480, v_fp: 6, v_sync: 8, v_bp: 23,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

    // 75 MHz pixel clock
    localparam timing_t MODE_HD_1280X720 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720, v_fp: 5, v_sync: 5, v_bp: 20,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

    // 1080p30 on the same 75 MHz pixel clock as 720p60
    localparam timing_t MODE_FHD_1920X1080 = '{
        h_active: 1920, h_fp: 88, h_sync: 44, h_bp: 148,
        v_active: 1080, v_fp: 4, v_sync: 5, v_bp: 36,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

`ifdef VIDEO_1080P
    localparam timing_t DEFAULT_MODE = MODE_FHD_1920X1080;
`elsif VIDEO_720P
    localparam timing_t DEFAULT_MODE = MODE_HD_1280X720;
`elsif VIDEO_480P
    localparam timing_t DEFAULT_MODE = MODE_WVGA_848X480;
`else
    localparam timing_t DEFAULT_MODE = MODE_VGA_640X480;
`endif

    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic logic is_active(input coord_t x, input coord_t y,
                                       input coord_t h_end, input coord_t v_end);
        return (x < h_end) && (y < v_end);
    endfunction

endpackage

// File: rtl/video_timing_gen_raster_counter.sv
// x/y raster position counter with clock enable, wrap, start pulses and a look-ahead
// of the position that will be loaded on the next clock edge.
module raster_counter
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int X_RESET = 799,
    parameter int Y_RESET = 524
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [11:0] next_x,
    output logic [11:0] next_y,
    output logic        line_start,
    output logic        frame_start
);

    localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t X_INIT = coord_t'(X_RESET);
    localparam coord_t Y_INIT = coord_t'(Y_RESET);

    always_comb begin
        next_x = x;
        next_y = y;
        if (ce) begin
            if (x == X_LAST) begin
                next_x = '0;
                next_y = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                next_x = x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= X_INIT;
            y           <= Y_INIT;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= next_x;
            y           <= next_y;
            // pulses only fire on a ce-qualified step onto column 0
            line_start  <= ce && (next_x == '0);
            frame_start <= ce && (next_x == '0) && (next_y == '0);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, blank, position and start pulses in the pixel clock domain.
// Define VTG_FETCH_AHEAD_EN to build the framebuffer fetch counter running FETCH_LEAD ahead.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEFAULT_MODE.h_active,
    parameter int H_FP       = DEFAULT_MODE.h_fp,
    parameter int H_SYNC     = DEFAULT_MODE.h_sync,
    parameter int H_BP       = DEFAULT_MODE.h_bp,
    parameter int V_ACTIVE   = DEFAULT_MODE.v_active,
    parameter int V_FP       = DEFAULT_MODE.v_fp,
    parameter int V_SYNC     = DEFAULT_MODE.v_sync,
    parameter int V_BP       = DEFAULT_MODE.v_bp,
    parameter bit HSYNC_POL  = DEFAULT_MODE.hsync_pol,
    parameter bit VSYNC_POL  = DEFAULT_MODE.vsync_pol,
    parameter int FETCH_LEAD = 8
) (
    input  logic        clk_pixel,
    input  logic        reset_i,
    input  logic        ce_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        line_start_o,
    output logic        frame_start_o,
    output logic        fetch_valid_o,
    output logic [11:0] fetch_x_o,
    output logic [11:0] fetch_y_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
    localparam coord_t H_SYNC_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SYNC_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
    localparam coord_t V_SYNC_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SYNC_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > COORD_LIMIT) begin : g_bad_h_total
        $error("video_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, COORD_LIMIT);
    end
    if (V_TOTAL > COORD_LIMIT) begin : g_bad_v_total
        $error("video_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, COORD_LIMIT);
    end

    coord_t next_x;
    coord_t next_y;

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .X_RESET (H_TOTAL - 1),
        .Y_RESET (V_TOTAL - 1)
    ) u_display (
        .clk         (clk_pixel),
        .reset       (reset_i),
        .ce          (ce_i),
        .x           (x_o),
        .y           (y_o),
        .next_x      (next_x),
        .next_y      (next_y),
        .line_start  (line_start_o),
        .frame_start (frame_start_o)
    );

    // Decode the position being loaded so sync/blank land in the same cycle as x_o/y_o.
    always_ff @(posedge clk_pixel) begin
        if (reset_i) begin
            blank_o <= 1'b1;
            hsync_o <= ~HSYNC_POL;
            vsync_o <= ~VSYNC_POL;
        end else begin
            blank_o <= ~is_active(next_x, next_y, H_ACT_END, V_ACT_END);
            hsync_o <= in_span(next_x, H_SYNC_BEG, H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_o <= in_span(next_y, V_SYNC_BEG, V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
        end
    end

`ifdef VTG_FETCH_AHEAD_EN
    localparam int FRAME_PIXELS = H_TOTAL * V_TOTAL;
    localparam int FETCH_RESET  = (FRAME_PIXELS - 1 + FETCH_LEAD) % FRAME_PIXELS;

    if ((FETCH_LEAD < 1) || (FETCH_LEAD >= H_FP + H_SYNC + H_BP)) begin : g_bad_fetch_lead
        $error("video_timing_gen: FETCH_LEAD %0d outside 1..%0d",
               FETCH_LEAD, H_FP + H_SYNC + H_BP - 1);
    end

    coord_t fetch_x;
    coord_t fetch_y;
    coord_t fetch_next_x;
    coord_t fetch_next_y;
    logic   fetch_line;
    logic   fetch_frame;

    // Parked FETCH_LEAD ce-steps past the display reset position.
    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .X_RESET (FETCH_RESET % H_TOTAL),
        .Y_RESET (FETCH_RESET / H_TOTAL)
    ) u_fetch (
        .clk         (clk_pixel),
        .reset       (reset_i),
        .ce          (ce_i),
        .x           (fetch_x),
        .y           (fetch_y),
        .next_x      (fetch_next_x),
        .next_y      (fetch_next_y),
        .line_start  (fetch_line),
        .frame_start (fetch_frame)
    );

    // Fetch outputs read zero until the first ce step after reset.
    always_ff @(posedge clk_pixel) begin
        if (reset_i) begin
            fetch_x_o     <= '0;
            fetch_y_o     <= '0;
            fetch_valid_o <= 1'b0;
        end else if (ce_i) begin
            fetch_x_o     <= fetch_next_x;
            fetch_y_o     <= fetch_next_y;
            fetch_valid_o <= is_active(fetch_next_x, fetch_next_y, H_ACT_END, V_ACT_END);
        end
    end

    logic unused_fetch;
    assign unused_fetch = ^{fetch_x, fetch_y, fetch_line, fetch_frame};
`else
    localparam int unused_fetch_lead = FETCH_LEAD;

    assign fetch_valid_o = 1'b0;
    assign fetch_x_o     = '0;
    assign fetch_y_o     = '0;
`endif

endmodule
